// File: rtl/hdpldadapt_tx_bond_rden_ctrl_if.sv
`default_nettype none
// hdpldadapt_tx_bond_rden_ctrl_if -- control/status bundle of the bonded TX read-enable controller.
// Rev 1.0
interface hdpldadapt_tx_bond_rden_ctrl_if #(
  parameter int TOWIDTH = 8,
  parameter int LKWIDTH = 4
);
  logic               rd_srst_n;
  logic               data_valid_in_raw;
  logic               comp_out_rden_en;
  logic               compin_sel_rden;
  logic               double_write_int;
  logic               fifo_empty;
  logic               r_bond_en;
  logic [LKWIDTH-1:0] r_lock_cnt;
  logic [TOWIDTH-1:0] r_comp_timeout;
  logic               fifo_rd_en;
  logic               rd_phase;
  logic               bond_locked;
  logic               bond_err;
  logic [15:0]        rden_ctrl_testbus;

  modport master (
    output rd_srst_n, data_valid_in_raw, comp_out_rden_en, compin_sel_rden,
           double_write_int, fifo_empty, r_bond_en, r_lock_cnt, r_comp_timeout,
    input  fifo_rd_en, rd_phase, bond_locked, bond_err, rden_ctrl_testbus
  );

  modport slave (
    input  rd_srst_n, data_valid_in_raw, comp_out_rden_en, compin_sel_rden,
           double_write_int, fifo_empty, r_bond_en, r_lock_cnt, r_comp_timeout,
    output fifo_rd_en, rd_phase, bond_locked, bond_err, rden_ctrl_testbus
  );
endinterface
`default_nettype wire

// File: rtl/hdpldadapt_tx_bond_rden_ctrl.sv
`default_nettype none
// hdpldadapt_tx_bond_rden_ctrl -- bonded TX FIFO read-enable control; debug bus enabled by
// HDPLDADAPT_TX_BOND_RDEN_TESTBUS_EN. Rev 1.0
module hdpldadapt_tx_bond_rden_ctrl #(
  parameter int TOWIDTH = 8,
  parameter int LKWIDTH = 4
) (
  input  logic                          tx_rdfifo_clk,
  input  logic                          tx_rdfifo_clk_rst_n,
  hdpldadapt_tx_bond_rden_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_COMP = 3'd1,
    ST_LOCKING   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_ERR       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LKWIDTH-1:0] lock_cnt_q, lock_cnt_d;
  logic [TOWIDTH-1:0] wdog_q, wdog_d;
  logic               fifo_rd_en_q, fifo_rd_en_d;
  logic               rd_phase_q, rd_phase_d;

  logic [LKWIDTH-1:0] lock_cnt_inc;
  logic [TOWIDTH-1:0] wdog_inc;
  logic               lock_done;
  logic               lock_first;
  logic               wdog_hit;
  logic               underflow;
  logic               rd_qual;

  assign lock_cnt_inc = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + LKWIDTH'(1);
  assign wdog_inc     = (&wdog_q) ? wdog_q : wdog_q + TOWIDTH'(1);
  // Extra bit keeps lock_cnt+1 from wrapping before the threshold compare.
  assign lock_done    = ({1'b0, lock_cnt_q} + (LKWIDTH+1)'(1)) >= {1'b0, bus.r_lock_cnt};
  assign lock_first   = bus.r_lock_cnt <= LKWIDTH'(1);
  assign wdog_hit     = wdog_q == bus.r_comp_timeout;
  assign underflow    = bus.data_valid_in_raw & bus.fifo_empty;

  assign rd_qual = bus.data_valid_in_raw & ~bus.fifo_empty & (state_q != ST_ERR) &
                   (~bus.r_bond_en | (state_q == ST_LOCKED));

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    wdog_d     = wdog_q;
    rd_phase_d = bus.double_write_int ? (rd_phase_q ^ rd_qual) : 1'b0;
    // The pop is issued together with the upper-word phase so both outputs line up.
    fifo_rd_en_d = rd_qual & (bus.double_write_int ? rd_phase_d : 1'b1);

    case (state_q)
      ST_IDLE: begin
        lock_cnt_d = '0;
        wdog_d     = '0;
        if (bus.r_bond_en && bus.compin_sel_rden) begin
          state_d = ST_WAIT_COMP;
        end
      end

      ST_WAIT_COMP: begin
        wdog_d = '0;
        if (!bus.r_bond_en) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else if (bus.comp_out_rden_en) begin
          lock_cnt_d = LKWIDTH'(1);
          state_d    = lock_first ? ST_LOCKED : ST_LOCKING;
        end
      end

      ST_LOCKING: begin
        if (!bus.r_bond_en) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          wdog_d     = '0;
        end else if (bus.comp_out_rden_en) begin
          lock_cnt_d = lock_cnt_inc;
          wdog_d     = '0;
          if (lock_done) begin
            state_d = ST_LOCKED;
          end
        end else if (wdog_hit) begin
          state_d    = ST_WAIT_COMP;
          lock_cnt_d = '0;
          wdog_d     = '0;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      ST_LOCKED: begin
        if (!bus.r_bond_en) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          wdog_d     = '0;
        end else if (underflow) begin
          state_d = ST_ERR;
        end else if (bus.comp_out_rden_en) begin
          lock_cnt_d = lock_cnt_inc;
          wdog_d     = '0;
        end else if (wdog_hit) begin
          state_d = ST_ERR;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        wdog_d     = '0;
      end
    endcase

    if (!bus.rd_srst_n) begin
      state_d      = ST_IDLE;
      lock_cnt_d   = '0;
      wdog_d       = '0;
      rd_phase_d   = 1'b0;
      fifo_rd_en_d = 1'b0;
    end
  end

  always_ff @(posedge tx_rdfifo_clk or negedge tx_rdfifo_clk_rst_n) begin
    if (!tx_rdfifo_clk_rst_n) begin
      state_q      <= ST_IDLE;
      lock_cnt_q   <= '0;
      wdog_q       <= '0;
      fifo_rd_en_q <= 1'b0;
      rd_phase_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      wdog_q       <= wdog_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      rd_phase_q   <= rd_phase_d;
    end
  end

  assign bus.fifo_rd_en  = fifo_rd_en_q;
  assign bus.rd_phase    = rd_phase_q;
  assign bus.bond_locked = (state_q == ST_LOCKED);
  assign bus.bond_err    = (state_q == ST_ERR);

`ifdef HDPLDADAPT_TX_BOND_RDEN_TESTBUS_EN
  logic [15:0] dbg_lock_cnt;
  logic [15:0] dbg_wdog;

  assign dbg_lock_cnt = 16'(lock_cnt_q);
  assign dbg_wdog     = 16'(wdog_q);
  assign bus.rden_ctrl_testbus = {state_q, dbg_lock_cnt[3:0], dbg_wdog[7:3], fifo_rd_en_q,
                                  rd_phase_q, (state_q == ST_ERR), bus.comp_out_rden_en};
`else
  assign bus.rden_ctrl_testbus = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdpldadapt_tx_bond_rden_ctrl.sv
`default_nettype none
// tb_hdpldadapt_tx_bond_rden_ctrl -- directed and randomized checks against a behavioural model.
// Rev 1.0
module tb_hdpldadapt_tx_bond_rden_ctrl;
  localparam int TOWIDTH = 8;
  localparam int LKWIDTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdpldadapt_tx_bond_rden_ctrl_if #(.TOWIDTH(TOWIDTH), .LKWIDTH(LKWIDTH)) bus ();

  hdpldadapt_tx_bond_rden_ctrl #(.TOWIDTH(TOWIDTH), .LKWIDTH(LKWIDTH)) dut (
    .tx_rdfifo_clk       (clk),
    .tx_rdfifo_clk_rst_n (rst_n),
    .bus                 (bus)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  // Model: mode 0 idle, 1 hunting for first pulse, 2 acquiring, 3 locked, 4 error.
  int m_mode;
  int m_pulses;
  int m_quiet;
  bit m_rd;
  bit m_ph;

  task automatic model_clear();
    m_mode = 0; m_pulses = 0; m_quiet = 0; m_rd = 1'b0; m_ph = 1'b0;
  endtask

  task automatic model_step();
    bit pulse;
    bit qual;
    int need;
    int limit;
    if (!bus.rd_srst_n) begin
      model_clear();
      return;
    end
    pulse = bus.comp_out_rden_en;
    limit = int'(bus.r_comp_timeout);
    need  = (int'(bus.r_lock_cnt) < 1) ? 1 : int'(bus.r_lock_cnt);
    qual  = bus.data_valid_in_raw && !bus.fifo_empty && (m_mode != 4) &&
            (!bus.r_bond_en || m_mode == 3);
    if (bus.double_write_int) begin
      m_ph = m_ph ^ qual;
      m_rd = qual && m_ph;
    end else begin
      m_ph = 1'b0;
      m_rd = qual;
    end
    if ((m_mode >= 1) && (m_mode <= 3) && !bus.r_bond_en) begin
      m_mode = 0; m_quiet = 0; m_pulses = 0;
      return;
    end
    case (m_mode)
      0: if (bus.r_bond_en && bus.compin_sel_rden) m_mode = 1;
      1: if (pulse) begin
           m_pulses = 1; m_quiet = 0;
           m_mode = (m_pulses >= need) ? 3 : 2;
         end
      2: if (pulse) begin
           m_pulses++; m_quiet = 0;
           if (m_pulses >= need) m_mode = 3;
         end else if (m_quiet == limit) begin
           m_mode = 1; m_quiet = 0; m_pulses = 0;
         end else begin
           m_quiet = (m_quiet < 255) ? m_quiet + 1 : 255;
         end
      3: if (bus.data_valid_in_raw && bus.fifo_empty) m_mode = 4;
         else if (pulse) m_quiet = 0;
         else if (m_quiet == limit) m_mode = 4;
         else m_quiet = (m_quiet < 255) ? m_quiet + 1 : 255;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("fifo_rd_en",  32'(bus.fifo_rd_en),  32'(m_rd));
    chk("rd_phase",    32'(bus.rd_phase),    32'(m_ph));
    chk("bond_locked", 32'(bus.bond_locked), 32'(m_mode == 3));
    chk("bond_err",    32'(bus.bond_err),    32'(m_mode == 4));
`ifndef HDPLDADAPT_TX_BOND_RDEN_TESTBUS_EN
    chk("testbus",     32'(bus.rden_ctrl_testbus), 32'h0);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int pops;
    int guard;
    bus.rd_srst_n         = 1'b1;
    bus.data_valid_in_raw = 1'b0;
    bus.comp_out_rden_en  = 1'b0;
    bus.compin_sel_rden   = 1'b0;
    bus.double_write_int  = 1'b0;
    bus.fifo_empty        = 1'b1;
    bus.r_bond_en         = 1'b0;
    bus.r_lock_cnt        = 4'd4;
    bus.r_comp_timeout    = 8'd20;
    model_clear();

    phase = "reset";
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    tick();

    phase = "bypass";
    bus.data_valid_in_raw = 1'b1;
    bus.fifo_empty        = 1'b0;
    tick();
    chk("bypass_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    chk("bypass_unlocked", 32'(bus.bond_locked), 32'd0);
    bus.data_valid_in_raw = 1'b0;
    tick();

    phase = "lock";
    bus.r_bond_en       = 1'b1;
    bus.compin_sel_rden = 1'b1;
    tick();
    for (int p = 1; p <= 4; p++) begin
      bus.comp_out_rden_en = 1'b1;
      tick();
      bus.comp_out_rden_en = 1'b0;
      chk($sformatf("locked_after_pulse%0d", p), 32'(bus.bond_locked), 32'(p == 4));
      if (p < 4) repeat (9) tick();
    end

    phase = "dwrite";
    pops = 0;
    bus.double_write_int  = 1'b1;
    bus.data_valid_in_raw = 1'b1;
    bus.fifo_empty        = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("dw_phase%0d", k), 32'(bus.rd_phase), 32'(k % 2));
      chk($sformatf("dw_pop%0d", k), 32'(bus.fifo_rd_en), 32'(k % 2));
      pops += int'(bus.fifo_rd_en);
    end
    chk("dw_pops", 32'(pops), 32'd4);
    bus.double_write_int  = 1'b0;
    bus.data_valid_in_raw = 1'b0;

    phase = "simul";
    guard = 0;
    while (m_quiet != 20 && guard < 100) begin
      tick();
      guard++;
    end
    chk("simul_reach", 32'(m_quiet), 32'd20);
    bus.comp_out_rden_en = 1'b1;
    tick();
    bus.comp_out_rden_en = 1'b0;
    chk("simul_no_err", 32'(bus.bond_err), 32'd0);
    chk("simul_locked", 32'(bus.bond_locked), 32'd1);
    repeat (20) tick();
    chk("wdog_cleared", 32'(bus.bond_locked), 32'd1);
    tick();
    chk("locked_timeout_err", 32'(bus.bond_err), 32'd1);
    bus.rd_srst_n = 1'b0;
    tick();
    bus.rd_srst_n = 1'b1;
    chk("srst_err_clr", 32'(bus.bond_err), 32'd0);

    phase = "underflow";
    bus.r_lock_cnt = 4'd1;
    tick();
    bus.comp_out_rden_en = 1'b1;
    tick();
    bus.comp_out_rden_en = 1'b0;
    chk("lock_first_pulse", 32'(bus.bond_locked), 32'd1);
    bus.data_valid_in_raw = 1'b1;
    bus.fifo_empty        = 1'b1;
    tick();
    chk("uf_err", 32'(bus.bond_err), 32'd1);
    chk("uf_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    bus.data_valid_in_raw = 1'b0;
    bus.rd_srst_n = 1'b0;
    tick();
    bus.rd_srst_n = 1'b1;
    chk("uf_err_clr", 32'(bus.bond_err), 32'd0);
    chk("uf_rd_en_clr", 32'(bus.fifo_rd_en), 32'd0);

    phase = "lockloss";
    bus.r_lock_cnt = 4'd4;
    tick();
    bus.comp_out_rden_en = 1'b1;
    tick();
    bus.comp_out_rden_en = 1'b0;
    repeat (25) tick();
    chk("loss_unlocked", 32'(bus.bond_locked), 32'd0);
    for (int p = 1; p <= 4; p++) begin
      bus.comp_out_rden_en = 1'b1;
      tick();
      bus.comp_out_rden_en = 1'b0;
      chk($sformatf("relock_pulse%0d", p), 32'(bus.bond_locked), 32'(p == 4));
      repeat (2) tick();
    end
    bus.r_bond_en = 1'b0;
    tick();
    chk("bond_en_drop", 32'(bus.bond_locked), 32'd0);

    phase = "random";
    for (int seg = 0; seg < 8; seg++) begin
      bus.r_lock_cnt       = LKWIDTH'($urandom_range(0, 5));
      bus.r_comp_timeout   = TOWIDTH'($urandom_range(3, 14));
      bus.double_write_int = 1'($urandom_range(0, 1));
      for (int c = 0; c < 300; c++) begin
        bus.r_bond_en         = ($urandom_range(0, 49) != 0);
        bus.compin_sel_rden   = ($urandom_range(0, 7) != 0);
        bus.comp_out_rden_en  = ($urandom_range(0, 4) == 0);
        bus.data_valid_in_raw = 1'($urandom_range(0, 1));
        bus.fifo_empty        = ($urandom_range(0, 9) == 0);
        bus.rd_srst_n         = ($urandom_range(0, 59) != 0);
        tick();
      end
      if (seg == 3) begin
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
